// File: rtl/l2tlb_l1resp_if.sv
// +----------------------------------------------------------------------+
// | Module  : l2tlb_l1resp_pkg / l2tlb_l1resp_if                          |
// | Brief   : Payload types and channel bundle between the L1 TLBs and   |
// |           the L2 TLB responder (req, ack, snoop, sack channels).     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package l2tlb_l1resp_pkg;

  typedef struct packed {
    logic [3:0]   txid;
    logic [38:12] laddr;
    logic         prefetch;
  } I_l1tlbtol2tlb_req_type;

  typedef struct packed {
    logic [3:0]  txid;
    logic        fault;
    logic        prefetch;
    logic [10:0] hpaddr;
    logic [2:0]  ppaddr;
  } I_l2tlbtol1tlb_ack_type;

  typedef struct packed {
    logic [10:0] hpaddr;
  } I_l2tlbtol1tlb_snoop_type;

  typedef struct packed {
    logic [10:0] hpaddr;
  } I_l1tlbtol2tlb_sack_type;

endpackage

// All four valid/retry channels between an L1 TLB and the L2 TLB.
interface l2tlb_l1resp_if;
  import l2tlb_l1resp_pkg::*;

  logic                     l1tlbtol2tlb_req_valid;
  logic                     l1tlbtol2tlb_req_retry;
  I_l1tlbtol2tlb_req_type   l1tlbtol2tlb_req;

  logic                     l2tlbtol1tlb_ack_valid;
  logic                     l2tlbtol1tlb_ack_retry;
  I_l2tlbtol1tlb_ack_type   l2tlbtol1tlb_ack;

  logic                     l2tlbtol1tlb_snoop_valid;
  logic                     l2tlbtol1tlb_snoop_retry;
  I_l2tlbtol1tlb_snoop_type l2tlbtol1tlb_snoop;

  logic                     l1tlbtol2tlb_sack_valid;
  logic                     l1tlbtol2tlb_sack_retry;
  I_l1tlbtol2tlb_sack_type  l1tlbtol2tlb_sack;

  // L1 TLB side
  modport master (
    output l1tlbtol2tlb_req_valid, l1tlbtol2tlb_req,
    input  l1tlbtol2tlb_req_retry,
    input  l2tlbtol1tlb_ack_valid, l2tlbtol1tlb_ack,
    output l2tlbtol1tlb_ack_retry,
    input  l2tlbtol1tlb_snoop_valid, l2tlbtol1tlb_snoop,
    output l2tlbtol1tlb_snoop_retry,
    output l1tlbtol2tlb_sack_valid, l1tlbtol2tlb_sack,
    input  l1tlbtol2tlb_sack_retry
  );

  // L2 TLB responder side
  modport slave (
    input  l1tlbtol2tlb_req_valid, l1tlbtol2tlb_req,
    output l1tlbtol2tlb_req_retry,
    output l2tlbtol1tlb_ack_valid, l2tlbtol1tlb_ack,
    input  l2tlbtol1tlb_ack_retry,
    output l2tlbtol1tlb_snoop_valid, l2tlbtol1tlb_snoop,
    input  l2tlbtol1tlb_snoop_retry,
    input  l1tlbtol2tlb_sack_valid, l1tlbtol2tlb_sack,
    output l1tlbtol2tlb_sack_retry
  );

endinterface

`default_nettype wire

// File: rtl/l2tlb_l1resp.sv
// +----------------------------------------------------------------------+
// | Module  : l2tlb_l1resp                                               |
// | Brief   : L2 TLB responder for the L1 TLB protocol. Returns identity |
// |           translations through an in-order ack FIFO and issues       |
// |           L2-initiated invalidation snoops, waiting for the sack.    |
// |           Optional macro L2TLB_FAULT_CHK_EN flags page numbers above |
// |           LADDR_LIMIT as faulting.                                   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module l2tlb_l1resp
  import l2tlb_l1resp_pkg::*;
#(
  parameter int          ACK_DEPTH   = 2,
  parameter logic [26:0] LADDR_LIMIT = 27'h0FF_FFFF
) (
  input  wire logic        clk,
  input  wire logic        reset,
  l2tlb_l1resp_if.slave    l1,
  input  wire logic        inv_valid,
  output logic             inv_retry,
  input  wire logic [10:0] inv_hpaddr,
  output logic             sack_err
);

  localparam int             c_AW   = (ACK_DEPTH > 1) ? $clog2(ACK_DEPTH) : 1;
  localparam logic [c_AW:0]  c_FULL = ACK_DEPTH[c_AW:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_SEND  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [10:0]             r_inv_hpaddr;
  logic                    r_sack_err;

  I_l2tlbtol1tlb_ack_type  r_mem [ACK_DEPTH];
  logic [c_AW-1:0]         r_wptr;
  logic [c_AW-1:0]         r_rptr;
  logic [c_AW:0]           r_count;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_inv_accept;
  logic                    w_req_retry;
  logic                    w_snoop_valid;
  logic                    w_sack_match;
  logic                    w_fault;
  I_l2tlbtol1tlb_ack_type  w_ack_entry;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);

  // Invalidates take priority over new requests, and no request may slip
  // in once a snoop is in flight, so acks never overtake the snoop.
  assign w_inv_accept = inv_valid && (r_state == S_IDLE);
  assign w_req_retry  = w_full || (r_state != S_IDLE) || inv_valid;

  assign w_push = l1.l1tlbtol2tlb_req_valid && !w_req_retry;
  assign w_pop  = !w_empty && !l1.l2tlbtol1tlb_ack_retry;

`ifdef L2TLB_FAULT_CHK_EN
  assign w_fault = (l1.l1tlbtol2tlb_req.laddr > LADDR_LIMIT);
`else
  logic w_unused_bits;
  assign w_fault       = 1'b0;
  assign w_unused_bits = ^{LADDR_LIMIT, l1.l1tlbtol2tlb_req.laddr[38:23]};
`endif

  // Identity translation of the incoming request.
  always_comb begin
    w_ack_entry          = '0;
    w_ack_entry.txid     = l1.l1tlbtol2tlb_req.txid;
    w_ack_entry.fault    = w_fault;
    w_ack_entry.prefetch = l1.l1tlbtol2tlb_req.prefetch;
    w_ack_entry.hpaddr   = l1.l1tlbtol2tlb_req.laddr[22:12];
    w_ack_entry.ppaddr   = l1.l1tlbtol2tlb_req.laddr[14:12];
  end

  // Ack FIFO storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_ack_entry;
    end
  end

  // Ack FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Snoop FSM state register and latched invalidate address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_inv_hpaddr <= '0;
    end else begin
      r_state <= w_next;
      if (w_inv_accept) begin
        r_inv_hpaddr <= inv_hpaddr;
      end
    end
  end

  assign w_sack_match = (r_state == S_WAIT) &&
                        (l1.l1tlbtol2tlb_sack.hpaddr == r_inv_hpaddr);

  // Snoop FSM next state and state-decoded outputs.
  always_comb begin
    w_next        = r_state;
    w_snoop_valid = 1'b0;
    inv_retry     = 1'b1;
    case (r_state)
      S_IDLE: begin
        inv_retry = 1'b0;
        if (inv_valid) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_empty) begin
          w_next = S_SEND;
        end
      end
      S_SEND: begin
        w_snoop_valid = 1'b1;
        if (!l1.l2tlbtol1tlb_snoop_retry) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (l1.l1tlbtol2tlb_sack_valid && w_sack_match) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Sticky error on any sack that does not close the outstanding snoop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sack_err <= 1'b0;
    end else if (l1.l1tlbtol2tlb_sack_valid && !w_sack_match) begin
      r_sack_err <= 1'b1;
    end
  end

  assign sack_err = r_sack_err;

  assign l1.l1tlbtol2tlb_req_retry   = w_req_retry;
  assign l1.l2tlbtol1tlb_ack_valid   = !w_empty;
  assign l1.l2tlbtol1tlb_ack         = r_mem[r_rptr];
  assign l1.l2tlbtol1tlb_snoop_valid = w_snoop_valid;
  assign l1.l2tlbtol1tlb_snoop       = r_inv_hpaddr;
  assign l1.l1tlbtol2tlb_sack_retry  = 1'b0;

endmodule

`default_nettype wire
